quick_sort_range: RTL and testbench

Parametrised successor to the in-place memory quick-sort engine. It sorts any sub-range `[lo, hi]` of an external single-port-style array, in ascending or descending order, with optional signed comparison. It uses an internal explicit stack with smaller-partition-first scheduling, which bounds stack depth to log2 of the range length, and it reports stack overflow. It sits between a controller issuing `start` and the shared array RAM (1-cycle read latency).

---
 rtl/quick_sort_range.sv | 171 +++++++++++++++++
 tb/tb_quick_sort_range.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quick_sort_range.sv
// quick_sort_range: in-place quick-sort of mem[lo..hi] over a 1-cycle-latency RAM, explicit stack, smaller partition first.
// Optional define QUICK_SORT_RANGE_SIGNED_EN: is_signed selects two's-complement comparison (otherwise unsigned).
module quick_sort_range #(
  parameter int MM = 256,
  parameter int MN = 32,
  parameter int MW = 8,
  parameter int SD = 8,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [MW-1:0] lo,
  input  logic [MW-1:0] hi,
  input  logic          descend,
  input  logic          is_signed,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          MemWr,
  output logic [MW-1:0] MemWrAddr,
  output logic [MN-1:0] MemWrData,
  output logic          MemRd,
  output logic [MW-1:0] MemRdAddr,
  input  logic [MN-1:0] MemRdData
);

  localparam logic [MW-1:0] ONE     = {{(MW-1){1'b0}}, 1'b1};
  localparam logic [MW-1:0] TWO     = {{(MW-2){1'b0}}, 2'b10};
  localparam logic [SW:0]   SP_FULL = SD[SW:0];
  localparam logic [SW:0]   SP_ONE  = {{SW{1'b0}}, 1'b1};
  localparam int            unused_mm = MM;

  typedef enum logic [4:0] {
    S_IDLE, S_SETUP, S_RD_PIV, S_GET_PIV, S_RD_R, S_GET_R, S_CMP_R, S_WR_R1, S_WR_R2,
    S_RD_L, S_GET_L, S_CMP_L, S_WR_L1, S_WR_L2, S_SPLIT, S_POP, S_DONE
  } state_t;

  state_t          r_state, w_nxt;
  logic [MW-1:0]   r_i, r_j, r_l, r_r, w_i, w_j, w_l, w_r;
  logic [MN-1:0]   r_v, r_x, w_v, w_x;
  logic            r_desc, r_sgn, r_err, w_desc, w_sgn, w_err, w_sgn_in;
  logic [SW:0]     r_sp;
  logic            w_push, w_pop;
  logic [2*MW-1:0] w_push_val, w_top;
  logic [2*MW-1:0] r_stk [SD];
  logic [MW-1:0]   w_ip1, w_im1, w_jm1, w_lenl, w_lenr;
  logic            w_lv, w_rv;

  function automatic logic f_before(input logic [MN-1:0] a, input logic [MN-1:0] b,
                                    input logic desc, input logic sgn);
    logic signed [MN-1:0] sa, sb;
    logic lt, gt;
    sa = a;
    sb = b;
    lt = sgn ? (sa < sb) : (a < b);
    gt = sgn ? (sa > sb) : (a > b);
    return desc ? gt : lt;
  endfunction

`ifdef QUICK_SORT_RANGE_SIGNED_EN
  assign w_sgn_in = is_signed;
`else
  logic w_unused_sgn;
  assign w_unused_sgn = is_signed;
  assign w_sgn_in     = 1'b0;
`endif

  assign w_ip1  = r_i + ONE;
  assign w_im1  = r_i - ONE;
  assign w_jm1  = r_j - ONE;
  // Partition sizes taken before any +/-1 so p==0 or p==MM-1 cannot wrap.
  assign w_lenl = r_i - r_l;
  assign w_lenr = r_r - r_i;
  assign w_lv   = (w_lenl >= TWO);
  assign w_rv   = (w_lenr >= TWO);
  assign w_top  = r_stk[r_sp[SW-1:0] + {SW{1'b1}}];

  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_DONE);
  assign error = r_err;

  always_comb begin
    w_nxt = r_state;  w_i = r_i;  w_j = r_j;  w_l = r_l;  w_r = r_r;
    w_v = r_v;  w_x = r_x;  w_desc = r_desc;  w_sgn = r_sgn;  w_err = r_err;
    w_push = 1'b0;  w_pop = 1'b0;  w_push_val = '0;
    MemRd = 1'b0;  MemRdAddr = '0;  MemWr = 1'b0;  MemWrAddr = '0;  MemWrData = '0;
    case (r_state)
      S_IDLE: if (start) begin
        w_nxt = S_SETUP;  w_i = lo;  w_j = hi;
        w_desc = descend;  w_sgn = w_sgn_in;  w_err = 1'b0;
      end
      S_SETUP: if (r_j <= r_i) w_nxt = S_DONE;
               else begin w_l = r_i;  w_r = r_j;  w_nxt = S_RD_PIV; end
      S_RD_PIV:  begin MemRd = 1'b1;  MemRdAddr = r_i;  w_nxt = S_GET_PIV; end
      S_GET_PIV: begin w_v = MemRdData;  w_nxt = S_RD_R; end
      S_RD_R:    begin MemRd = 1'b1;  MemRdAddr = r_j;  w_nxt = S_GET_R; end
      S_GET_R:   begin w_x = MemRdData;  w_nxt = S_CMP_R; end
      S_CMP_R: if (f_before(r_v, r_x, r_desc, r_sgn)) begin
        w_j = w_jm1;
        w_nxt = (r_i == w_jm1) ? S_SPLIT : S_RD_R;
      end else w_nxt = S_WR_R1;
      S_WR_R1: begin MemWr = 1'b1;  MemWrAddr = r_i;  MemWrData = r_x;  w_nxt = S_WR_R2; end
      S_WR_R2: begin
        MemWr = 1'b1;  MemWrAddr = r_j;  MemWrData = r_v;  w_i = w_ip1;
        w_nxt = (w_ip1 == r_j) ? S_SPLIT : S_RD_L;
      end
      S_RD_L:  begin MemRd = 1'b1;  MemRdAddr = r_i;  w_nxt = S_GET_L; end
      S_GET_L: begin w_x = MemRdData;  w_nxt = S_CMP_L; end
      S_CMP_L: if (f_before(r_x, r_v, r_desc, r_sgn)) begin
        w_i = w_ip1;
        w_nxt = (w_ip1 == r_j) ? S_SPLIT : S_RD_L;
      end else w_nxt = S_WR_L1;
      S_WR_L1: begin MemWr = 1'b1;  MemWrAddr = r_j;  MemWrData = r_x;  w_nxt = S_WR_L2; end
      S_WR_L2: begin
        MemWr = 1'b1;  MemWrAddr = r_i;  MemWrData = r_v;  w_j = w_jm1;
        w_nxt = (w_jm1 == r_i) ? S_SPLIT : S_RD_R;
      end
      S_SPLIT: begin
        w_nxt = S_RD_PIV;
        if (w_lv && w_rv) begin
          if (r_sp == SP_FULL) begin
            w_err = 1'b1;  w_nxt = S_DONE;
          end else begin
            // Defer the larger side; equal sizes defer the right side.
            w_push = 1'b1;
            if (w_lenr >= w_lenl) begin w_push_val = {w_ip1, r_r};  w_r = w_im1; end
            else begin w_push_val = {r_l, w_im1};  w_l = w_ip1; end
          end
        end else if (w_lv) w_r = w_im1;
        else if (w_rv) w_l = w_ip1;
        else w_nxt = S_POP;
        w_i = w_l;
        w_j = w_r;
      end
      S_POP: if (r_sp == '0) w_nxt = S_DONE;
             else begin
               w_pop = 1'b1;  {w_l, w_r} = w_top;  w_i = w_top[2*MW-1:MW];
               w_j = w_top[MW-1:0];  w_nxt = S_RD_PIV;
             end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_err   <= 1'b0;
      r_sp    <= '0;
    end else begin
      r_state <= w_nxt;
      r_err   <= w_err;
      if (w_push)     r_sp <= r_sp + SP_ONE;
      else if (w_pop) r_sp <= r_sp - SP_ONE;
    end
  end

  always_ff @(posedge clk) begin
    r_i    <= w_i;
    r_j    <= w_j;
    r_l    <= w_l;
    r_r    <= w_r;
    r_v    <= w_v;
    r_x    <= w_x;
    r_desc <= w_desc;
    r_sgn  <= w_sgn;
    if (w_push) r_stk[r_sp[SW-1:0]] <= w_push_val;
  end

endmodule

// File: tb/tb_quick_sort_range.sv
// Bench for quick_sort_range: directed vectors plus random arrays checked against a plain quick-sort model.
module tb_quick_sort_range;
  localparam int LIM = 30000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start0, start1, desc_i, sgn_i;
  logic [7:0]  lo_i, hi_i;
  logic        busy0, done0, err0, wr0, rd0, busy1, done1, err1, wr1, rd1;
  logic [7:0]  wa0, ra0, wa1, ra1;
  logic [31:0] wd0, rdd0, wd1, rdd1;

  quick_sort_range #(.MM(256), .MN(32), .MW(8), .SD(8), .SW(3)) u_dut0 (
    .clk(clk), .reset(rst), .start(start0), .lo(lo_i), .hi(hi_i), .descend(desc_i),
    .is_signed(sgn_i), .busy(busy0), .done(done0), .error(err0), .MemWr(wr0),
    .MemWrAddr(wa0), .MemWrData(wd0), .MemRd(rd0), .MemRdAddr(ra0), .MemRdData(rdd0));

  quick_sort_range #(.MM(256), .MN(32), .MW(8), .SD(2), .SW(1)) u_dut1 (
    .clk(clk), .reset(rst), .start(start1), .lo(lo_i), .hi(hi_i), .descend(desc_i),
    .is_signed(sgn_i), .busy(busy1), .done(done1), .error(err1), .MemWr(wr1),
    .MemWrAddr(wa1), .MemWrData(wd1), .MemRd(rd1), .MemRdAddr(ra1), .MemRdData(rdd1));

  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  logic [31:0] img  [256];
  logic [31:0] mdl  [256];
  logic        ld_en, ld_sel, trk_clr;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  int          amin, amax, nacc, both, nd0, nd1;
  int          n_chk = 0, n_pass = 0, n_fail = 0;

  always @(posedge clk) begin
    if (ld_en && !ld_sel) mem0[ld_addr] <= ld_data;
    if (wr0) mem0[wa0] <= wd0;
    if (rd0) rdd0 <= mem0[ra0];
  end

  always @(posedge clk) begin
    if (ld_en && ld_sel) mem1[ld_addr] <= ld_data;
    if (wr1) mem1[wa1] <= wd1;
    if (rd1) rdd1 <= mem1[ra1];
  end

  always @(posedge clk) begin
    if (trk_clr) begin
      amin <= 255;  amax <= 0;  nacc <= 0;  both <= 0;  nd0 <= 0;  nd1 <= 0;
    end else begin
      if (rd0) begin
        nacc <= nacc + 1;
        if (int'(ra0) < amin) amin <= int'(ra0);
        if (int'(ra0) > amax) amax <= int'(ra0);
      end
      if (wr0) begin
        nacc <= nacc + 1;
        if (int'(wa0) < amin) amin <= int'(wa0);
        if (int'(wa0) > amax) amax <= int'(wa0);
      end
      if (rd0 && wr0) both <= 1;
      if (done0) nd0 <= nd0 + 1;
      if (done1) nd1 <= nd1 + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit seff(input bit s);
`ifdef QUICK_SORT_RANGE_SIGNED_EN
    return s;
`else
    return 1'b0 & s;
`endif
  endfunction

  function automatic bit bef(input logic [31:0] a, input logic [31:0] b, input bit d, input bit s);
    if (s) return d ? ($signed(a) > $signed(b)) : ($signed(a) < $signed(b));
    return d ? (a > b) : (a < b);
  endfunction

  // Reference: hole-based quick-sort on mdl with a LIFO of deferred ranges.
  task automatic model_run(input int lo, input int hi, input bit d, input bit s, input int sd,
                           output bit err);
    int l, r, i, j, p;
    logic [31:0] v;
    int ql[$], qr[$];
    bit more;
    err = 1'b0;
    if (hi <= lo) return;
    l = lo;  r = hi;  more = 1'b1;
    while (more) begin
      i = l;  j = r;  v = mdl[i];
      while (i < j) begin
        while (i < j && bef(v, mdl[j], d, s)) j--;
        if (i < j) begin mdl[i] = mdl[j];  mdl[j] = v;  i++; end
        while (i < j && bef(mdl[i], v, d, s)) i++;
        if (i < j) begin mdl[j] = mdl[i];  mdl[i] = v;  j--; end
      end
      p = i;
      if (p - l >= 2 && r - p >= 2) begin
        if (ql.size() == sd) begin err = 1'b1;  return; end
        if (r - p >= p - l) begin ql.push_back(p + 1);  qr.push_back(r);  r = p - 1; end
        else begin ql.push_back(l);  qr.push_back(p - 1);  l = p + 1; end
      end else if (p - l >= 2) r = p - 1;
      else if (r - p >= 2) l = p + 1;
      else if (ql.size() == 0) more = 1'b0;
      else begin l = ql.pop_back();  r = qr.pop_back(); end
    end
  endtask

  function automatic int diff_mdl(input bit sel);
    int n = 0;
    for (int k = 0; k < 256; k++) if ((sel ? mem1[k] : mem0[k]) !== mdl[k]) n++;
    return n;
  endfunction

  function automatic int unsorted(input int lo, input int hi, input bit d, input bit s);
    int n = 0;
    for (int k = lo; k < hi; k++) if (bef(mem0[k+1], mem0[k], d, s)) n++;
    return n;
  endfunction

  task automatic load(input bit sel);
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      ld_en = 1'b1;  ld_sel = sel;  ld_addr = 8'(k);  ld_data = img[k];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic copy_mdl();
    for (int k = 0; k < 256; k++) mdl[k] = img[k];
  endtask

  task automatic run(input bit sel, input logic [7:0] l, input logic [7:0] h, input bit d,
                     input bit s, output int cyc);
    @(negedge clk);
    trk_clr = 1'b1;
    @(negedge clk);
    trk_clr = 1'b0;  lo_i = l;  hi_i = h;  desc_i = d;  sgn_i = s;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;  start1 = 1'b0;  cyc = 1;
    while (((sel ? done1 : done0) !== 1'b1) && cyc < LIM) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_reached", 64'(cyc < LIM), 64'(1));
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int cyc, bad, l, h;
    bit merr, d, s;
    logic [31:0] e8 [8];
    rst = 1'b1;  start0 = 1'b0;  start1 = 1'b0;  lo_i = '0;  hi_i = '0;
    desc_i = 1'b0;  sgn_i = 1'b0;  ld_en = 1'b0;  ld_sel = 1'b0;  ld_addr = '0;
    ld_data = '0;  trk_clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy0), 64'(0));
    chk("rst_done", 64'(done0), 64'(0));
    chk("rst_error", 64'(err0), 64'(0));
    chk("rst_strobes", 64'({rd0, wr0, rd1, wr1, busy1}), 64'(0));
    chk("rst_addr_data", 64'({ra0, wa0, wd0}), 64'(0));
    rst = 1'b0;
    trk_clr = 1'b0;

    // Ascending 0..7
    for (int k = 0; k < 256; k++) img[k] = $urandom;
    e8 = '{5, 3, 8, 1, 9, 2, 7, 4};
    for (int k = 0; k < 8; k++) img[k] = e8[k];
    load(0);
    run(0, 8'd0, 8'd7, 1'b0, 1'b0, cyc);
    e8 = '{1, 2, 3, 4, 5, 7, 8, 9};
    bad = 0;
    for (int k = 0; k < 8; k++) if (mem0[k] !== e8[k]) bad++;
    chk("asc8_data", 64'(bad), 64'(0));
    chk("asc8_error", 64'(err0), 64'(0));
    chk("asc8_done_pulses", 64'(nd0), 64'(1));
    chk("asc8_rd_wr_overlap", 64'(both), 64'(0));
    chk("asc8_busy_after", 64'(busy0), 64'(0));

    // Descending sub-range 2..5
    e8 = '{9, 9, 1, 4, 3, 2, 0, 0};
    for (int k = 0; k < 8; k++) img[k] = e8[k];
    load(0);
    run(0, 8'd2, 8'd5, 1'b1, 1'b0, cyc);
    e8 = '{9, 9, 4, 3, 2, 1, 0, 0};
    bad = 0;
    for (int k = 0; k < 8; k++) if (mem0[k] !== e8[k]) bad++;
    chk("desc_data", 64'(bad), 64'(0));
    chk("desc_amin", 64'(amin), 64'(2));
    chk("desc_amax", 64'(amax), 64'(5));

    // Trivial ranges
    run(0, 8'd4, 8'd4, 1'b0, 1'b0, cyc);
    chk("triv_eq_latency", 64'(cyc), 64'(2));
    chk("triv_eq_noaccess", 64'(nacc), 64'(0));
    chk("triv_eq_pulses", 64'(nd0), 64'(1));
    run(0, 8'd5, 8'd3, 1'b0, 1'b0, cyc);
    chk("triv_inv_latency", 64'(cyc), 64'(2));
    chk("triv_inv_noaccess", 64'(nacc), 64'(0));

    // Signed compare selection
    img[0] = 32'h1;  img[1] = 32'hFFFF_FFFF;  img[2] = 32'h7FFF_FFFF;  img[3] = 32'hFFFF_FF80;
    load(0);
    run(0, 8'd0, 8'd3, 1'b0, 1'b1, cyc);
`ifdef QUICK_SORT_RANGE_SIGNED_EN
    e8 = '{32'hFFFF_FF80, 32'hFFFF_FFFF, 32'h1, 32'h7FFF_FFFF, 0, 0, 0, 0};
`else
    e8 = '{32'h1, 32'h7FFF_FFFF, 32'hFFFF_FF80, 32'hFFFF_FFFF, 0, 0, 0, 0};
`endif
    bad = 0;
    for (int k = 0; k < 4; k++) if (mem0[k] !== e8[k]) bad++;
    chk("signed_data", 64'(bad), 64'(0));

    // Random sub-ranges with duplicates and negative values
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 256; k++) img[k] = 32'($urandom_range(0, 20)) - 32'd10;
      l = $urandom_range(0, 150);
      h = l + $urandom_range(1, 100);
      d = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      load(0);
      run(0, 8'(l), 8'(h), d, s, cyc);
      copy_mdl();
      model_run(l, h, d, seff(s), 8, merr);
      chk("rnd_range_model", 64'(diff_mdl(0)), 64'(0));
      chk("rnd_range_sorted", 64'(unsorted(l, h, d, seff(s))), 64'(0));
      chk("rnd_range_error", 64'(err0), 64'(merr));
    end

    // Overflow with SD=2: pick an image the reference says nests deeper than 2
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 256; k++) img[k] = $urandom;
      copy_mdl();
      model_run(0, 255, 1'b0, 1'b0, 2, merr);
      if (merr) break;
    end
    load(1);
    run(1, 8'd0, 8'd255, 1'b0, 1'b0, cyc);
    copy_mdl();
    model_run(0, 255, 1'b0, 1'b0, 2, merr);
    chk("ovf_error", 64'(err1), 64'(merr));
    chk("ovf_perm_model", 64'(diff_mdl(1)), 64'(0));
    chk("ovf_done_pulses", 64'(nd1), 64'(1));
    repeat (3) @(negedge clk);
    chk("ovf_error_held", 64'(err1), 64'(merr));

    // Same image with SD=8: full 256-entry ascending sort
    load(0);
    run(0, 8'd0, 8'd255, 1'b0, 1'b0, cyc);
    copy_mdl();
    model_run(0, 255, 1'b0, 1'b0, 8, merr);
    chk("full_error", 64'(err0), 64'(0));
    chk("full_model", 64'(diff_mdl(0)), 64'(0));
    chk("full_sorted", 64'(unsorted(0, 255, 1'b0, 1'b0)), 64'(0));
    chk("full_rd_wr_overlap", 64'(both), 64'(0));

    // Reset mid-sort, then all-equal data
    for (int k = 0; k < 256; k++) img[k] = $urandom;
    load(0);
    lo_i = 8'd0;  hi_i = 8'd255;  desc_i = 1'b0;  sgn_i = 1'b0;  start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (200) @(negedge clk);
    chk("midrun_busy", 64'(busy0), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(busy0), 64'(0));
    chk("midrst_strobes", 64'({rd0, wr0, done0}), 64'(0));
    rst = 1'b0;
    for (int k = 0; k < 256; k++) img[k] = (k < 16) ? 32'd7 : 32'd100;
    load(0);
    run(0, 8'd0, 8'd15, 1'b0, 1'b0, cyc);
    bad = 0;
    for (int k = 0; k < 16; k++) if (mem0[k] !== 32'd7) bad++;
    chk("equal_data", 64'(bad), 64'(0));
    chk("equal_error", 64'(err0), 64'(0));
    chk("equal_pulses", 64'(nd0), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
